uart_tx_arbiter: RTL

// Shares the single 24-bit send-only UART between NUM_REQ requesters (e.g. bus

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester handshake, the UART-facing signals and the arbiter status.
// The arbiter connects through the slave modport; the requester/UART side uses master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic [23:0]           uart_tx_data;
  logic                  uart_transmit;
  logic                  uart_tx_empty;
  logic [2:0]            grant_id;
  logic                  busy;
  logic [7:0]            retry_count;

  modport slave (
    input  req_valid, req_data, uart_tx_empty,
    output req_ack, uart_tx_data, uart_transmit, grant_id, busy, retry_count
  );

  modport master (
    output req_valid, req_data, uart_tx_empty,
    input  req_ack, uart_tx_data, uart_transmit, grant_id, busy, retry_count
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 24-bit send-only UART between NUM_REQ requesters.
// Each grant captures one word, pulses transmit, retries on a missed accept and waits for completion.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ACCEPT_TIMEOUT = 7
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_transmit;
  logic [23:0]          r_tx_data;
  logic [2:0]           r_grant_id;
  logic [7:0]           r_retry_count;
  logic [3:0]           r_timer;

  state_t               w_state_next;
  logic [NUM_REQ-1:0]   w_ack_next;
  logic                 w_transmit_next;
  logic [23:0]          w_tx_data_next;
  logic [2:0]           w_grant_next;
  logic [7:0]           w_retry_next;
  logic [3:0]           w_timer_next;
  logic [3:0]           w_timer_inc;

  logic                 w_sel_valid;
  logic [2:0]           w_sel;
  logic [NUM_REQ-1:0]   w_sel_onehot;
  logic [23:0]          w_sel_word;
  logic [23:0]          w_words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_words[gi] = bus.req_data[24*gi +: 24];
  end

  // Walk from the farthest candidate to the nearest so the nearest valid one
  // after the current owner wins; the current owner itself is the farthest.
  always_comb begin
    logic [3:0] v_idx;
    w_sel        = r_grant_id;
    w_sel_valid  = 1'b0;
    w_sel_onehot = '0;
    w_sel_word   = r_tx_data;
    v_idx        = 4'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = {1'b0, r_grant_id} + 4'(k);
      if (v_idx >= 4'(NUM_REQ)) begin
        v_idx = v_idx - 4'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (v_idx == 4'(j) && bus.req_valid[j]) begin
          w_sel        = 3'(j);
          w_sel_valid  = 1'b1;
          w_sel_onehot = '0;
          w_sel_onehot[j] = 1'b1;
          w_sel_word   = w_words[j];
        end
      end
    end
  end

  assign w_timer_inc = r_timer + 4'd1;

  always_comb begin
    w_state_next    = r_state;
    w_ack_next      = '0;
    w_transmit_next = 1'b0;
    w_tx_data_next  = r_tx_data;
    w_grant_next    = r_grant_id;
    w_retry_next    = r_retry_count;
    w_timer_next    = r_timer;
    case (r_state)
      S_IDLE: begin
        if (bus.uart_tx_empty && w_sel_valid) begin
          w_tx_data_next  = w_sel_word;
          w_grant_next    = w_sel;
          w_ack_next      = w_sel_onehot;
          w_transmit_next = 1'b1;
          w_state_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_timer_next = 4'd0;
        w_state_next = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (!bus.uart_tx_empty) begin
          w_state_next = S_WAIT_DONE;
        end else begin
          w_timer_next = w_timer_inc;
          if (w_timer_inc == 4'(ACCEPT_TIMEOUT)) begin
            w_transmit_next = 1'b1;
            w_state_next    = S_ISSUE;
            if (r_retry_count != 8'hFF) begin
              w_retry_next = r_retry_count + 8'd1;
            end
          end
        end
      end
      S_WAIT_DONE: begin
        if (bus.uart_tx_empty) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // transmit and ack are registered against the next state, so they are high
  // exactly during the ISSUE cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_ack         <= '0;
      r_transmit    <= 1'b0;
      r_tx_data     <= 24'h000000;
      r_grant_id    <= 3'(NUM_REQ - 1);
      r_retry_count <= 8'd0;
      r_timer       <= 4'd0;
    end else begin
      r_state       <= w_state_next;
      r_ack         <= w_ack_next;
      r_transmit    <= w_transmit_next;
      r_tx_data     <= w_tx_data_next;
      r_grant_id    <= w_grant_next;
      r_retry_count <= w_retry_next;
      r_timer       <= w_timer_next;
    end
  end

  assign bus.req_ack       = r_ack;
  assign bus.uart_transmit = r_transmit;
  assign bus.uart_tx_data  = r_tx_data;
  assign bus.grant_id      = r_grant_id;
  assign bus.retry_count   = r_retry_count;
  assign bus.busy          = (r_state != S_IDLE);

endmodule
